rc4_key_search_ctrl: RTL and testbench
======================================

# rc4_key_search_ctrl

Top-level sequencer for the RC4 key-search datapath. For each candidate key it runs three phases in order: S-memory initialise, key-schedule shuffle, then message decrypt. It owns the single S-memory port and hands it to whichever phase is active. While decrypt runs, it checks every plaintext byte; on any bad byte it advances to the next key, and it stops when a key yields a fully printable message or the key range is used up.

## Interface
Parameters:
- KEY_WIDTH, 24, candidate key width in bits
- KEY_START, 24'h000000, first key tried
- KEY_END, 24'h3FFFFF, last key tried (inclusive; must be >= KEY_START)
- MSG_LEN, 32, plaintext bytes expected per decrypt run

Ports (clock and reset first):
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level; sampled in IDLE, FOUND, EXHAUSTED
- init_start / ksa_start / dec_start  out  1 each  phase start, held high until that phase's finish is seen
- init_finish / ksa_finish / dec_finish  in  1 each  phase done (sticky in sub-block)
- sub_reset  out  1  one-cycle pulse returning all three sub-blocks to their wait state
- init_s_address / ksa_s_address / dec_s_address  in  8 each  requester S address
- init_s_write_data / ksa_s_write_data / dec_s_write_data  in  8 each  requester S write data
- init_s_write / ksa_s_write / dec_s_write  in  1 each  requester S write enable
- s_address, s_write_data  out  8 each  muxed to S memory
- s_write  out  1  muxed S write enable
- dec_ram_write  in  1  decrypt plaintext write strobe (snooped)
- dec_ram_write_data  in  8  decrypt plaintext byte (snooped)
- key  out  KEY_WIDTH  candidate key currently under test
- key_found  out  1  level; the value on key is valid
- key_fail  out  1  level; range exhausted, no key found
- busy  out  1  high in every state except IDLE, FOUND, EXHAUSTED

## Operation
States and transitions:
- IDLE: if start, go to RESET_SUBS; key <= KEY_START.
- RESET_SUBS: sub_reset=1; bad <= 0; byte_cnt <= 0; go to INIT.
- INIT: init_start=1; on init_finish go to KSA.
- KSA: ksa_start=1; on ksa_finish go to DEC.
- DEC: dec_start=1; on dec_finish go to CHECK.
- CHECK:
  - if !bad and byte_cnt==MSG_LEN, go to FOUND;
  - else if key==KEY_END, go to EXHAUSTED;
  - else key <= key+1 and go to RESET_SUBS.
- FOUND / EXHAUSTED: outputs held; start restarts the search (key <= KEY_START, go to RESET_SUBS).

S-port mux:
- Select is decoded from the registered state: INIT selects init_*, KSA selects ksa_*, DEC selects dec_*.
- All other states drive s_address=0, s_write_data=0, s_write=0.
- Writes from non-selected requesters are ignored.

Plaintext checker:
- Acts on each cycle with dec_ram_write=1 while in DEC; byte_cnt increments (saturating at MSG_LEN).
- A byte is good if it is 8'h20 or in 8'h61..8'h7A inclusive. Any other byte sets the sticky bit bad.
- A byte_cnt shortfall at CHECK is also a failure.

Arithmetic:
- key+1 is KEY_WIDTH wide; it never wraps, because the KEY_END compare happens first.

## Timing
- Reset values:
  - state=IDLE, key=KEY_START.
  - key_found, key_fail, busy, sub_reset, all *_start, s_write = 0.
  - s_address = 0, s_write_data = 0.
- Reset mid-operation: takes effect on the next edge. The sub-blocks are not pulsed; the next RESET_SUBS clears them.
- All control outputs are registered or decoded from state. The S mux and checker are combinational from requester inputs (zero-cycle path to memory).
- Phase transitions: a finish sampled high moves to the next state on that edge, and that phase's start deasserts in the same cycle the next phase's start asserts.
- Per-key overhead: 2 cycles (RESET_SUBS, CHECK) plus the sub-block latencies.
- key_found and key_fail assert on the edge that leaves CHECK and stay high until reset or restart.
- Simultaneous events:
  - dec_ram_write coincident with dec_finish: the byte is checked before CHECK.
  - start high in FOUND the cycle after entry: restart is honoured.

## Configuration
- RC4_EARLY_ABORT_EN defined: in DEC, the first bad byte moves the controller straight to CHECK on the next edge without waiting for dec_finish. The abort is taken one cycle after the byte, and sub_reset follows via RESET_SUBS (or EXHAUSTED when key==KEY_END).
- Undefined: DEC always waits for dec_finish; total cycles per key are data-independent.

## Test plan
- Behavioural sub-block models, message encrypted with key 24'h000003, KEY_START=0 -> four trials; key_found=1, key=24'h000003, key_fail=0, busy=0.
- KEY_END=24'h000003, all keys produce byte 8'h00 -> key_fail=1 after key 3, key_found=0, key unchanged at 3.
- Checker boundaries: each byte in turn set to 8'h60, 8'h7B, 8'h1F -> fail. Bytes 8'h61, 8'h7A, 8'h20 -> pass.
- During KSA, init_s_write=1 with init_s_address=8'hAA -> s_write equals ksa_s_write and s_address equals ksa_s_address.
- reset asserted for one cycle in DEC -> next cycle state=IDLE, busy=0, dec_start=0, key=KEY_START, s_write=0.
- RC4_EARLY_ABORT_EN, bad first byte at cycle T -> CHECK at T+1, sub_reset=1 at T+2, with no wait on dec_finish.

Source files
------------

// File: rtl/rc4_key_search_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rc4_key_search_ctrl                                                       |
// | Per-key init/KSA/decrypt sequencer, S-memory port owner, plaintext check. |
// | Option macro: RC4_EARLY_ABORT_EN (leave DEC on the first bad byte).       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rc4_key_search_ctrl #(
   parameter int                   KEY_WIDTH = 24,
   parameter logic [KEY_WIDTH-1:0] KEY_START = 24'h000000,
   parameter logic [KEY_WIDTH-1:0] KEY_END   = 24'h3FFFFF,
   parameter int                   MSG_LEN   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 init_start,
   output logic                 ksa_start,
   output logic                 dec_start,
   input  logic                 init_finish,
   input  logic                 ksa_finish,
   input  logic                 dec_finish,
   output logic                 sub_reset,
   input  logic [7:0]           init_s_address,
   input  logic [7:0]           ksa_s_address,
   input  logic [7:0]           dec_s_address,
   input  logic [7:0]           init_s_write_data,
   input  logic [7:0]           ksa_s_write_data,
   input  logic [7:0]           dec_s_write_data,
   input  logic                 init_s_write,
   input  logic                 ksa_s_write,
   input  logic                 dec_s_write,
   output logic [7:0]           s_address,
   output logic [7:0]           s_write_data,
   output logic                 s_write,
   input  logic                 dec_ram_write,
   input  logic [7:0]           dec_ram_write_data,
   output logic [KEY_WIDTH-1:0] key,
   output logic                 key_found,
   output logic                 key_fail,
   output logic                 busy
);

   localparam int                 c_cnt_w   = $clog2(MSG_LEN + 1);
   localparam logic [c_cnt_w-1:0] c_msg_len = c_cnt_w'(MSG_LEN);

   localparam logic [2:0] c_st_idle       = 3'd0;
   localparam logic [2:0] c_st_reset_subs = 3'd1;
   localparam logic [2:0] c_st_init       = 3'd2;
   localparam logic [2:0] c_st_ksa        = 3'd3;
   localparam logic [2:0] c_st_dec        = 3'd4;
   localparam logic [2:0] c_st_check      = 3'd5;
   localparam logic [2:0] c_st_found      = 3'd6;
   localparam logic [2:0] c_st_exhausted  = 3'd7;

   logic [2:0]           state_q, state_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic                 bad_q, bad_d;
   logic [c_cnt_w-1:0]   byte_cnt_q, byte_cnt_d;
   logic                 w_byte_strobe;
   logic                 w_byte_good;

   // Printable set for the expected message: space or lower-case letters.
   assign w_byte_good   = (dec_ram_write_data == 8'h20) ||
                          ((dec_ram_write_data >= 8'h61) && (dec_ram_write_data <= 8'h7A));
   assign w_byte_strobe = (state_q == c_st_dec) && dec_ram_write;

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      bad_d      = bad_q;
      byte_cnt_d = byte_cnt_q;

      if (w_byte_strobe) begin
         if (byte_cnt_q != c_msg_len) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
         end
         if (!w_byte_good) begin
            bad_d = 1'b1;
         end
      end

      case (state_q)
         c_st_idle, c_st_found, c_st_exhausted: begin
            if (start) begin
               state_d = c_st_reset_subs;
               key_d   = KEY_START;
            end
         end
         c_st_reset_subs: begin
            bad_d      = 1'b0;
            byte_cnt_d = '0;
            state_d    = c_st_init;
         end
         c_st_init: begin
            if (init_finish) state_d = c_st_ksa;
         end
         c_st_ksa: begin
            if (ksa_finish) state_d = c_st_dec;
         end
         c_st_dec: begin
`ifdef RC4_EARLY_ABORT_EN
            if (dec_finish || (w_byte_strobe && !w_byte_good)) state_d = c_st_check;
`else
            if (dec_finish) state_d = c_st_check;
`endif
         end
         c_st_check: begin
            // KEY_END is tested before incrementing, so key never wraps.
            if (!bad_q && (byte_cnt_q == c_msg_len)) begin
               state_d = c_st_found;
            end else if (key_q == KEY_END) begin
               state_d = c_st_exhausted;
            end else begin
               key_d   = key_q + 1'b1;
               state_d = c_st_reset_subs;
            end
         end
         default: state_d = c_st_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= c_st_idle;
         key_q      <= KEY_START;
         bad_q      <= 1'b0;
         byte_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         bad_q      <= bad_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   // S port goes to the requester of the current phase; everyone else is ignored.
   always_comb begin
      s_address    = 8'h00;
      s_write_data = 8'h00;
      s_write      = 1'b0;
      case (state_q)
         c_st_init: begin
            s_address    = init_s_address;
            s_write_data = init_s_write_data;
            s_write      = init_s_write;
         end
         c_st_ksa: begin
            s_address    = ksa_s_address;
            s_write_data = ksa_s_write_data;
            s_write      = ksa_s_write;
         end
         c_st_dec: begin
            s_address    = dec_s_address;
            s_write_data = dec_s_write_data;
            s_write      = dec_s_write;
         end
         default: begin
            s_address    = 8'h00;
            s_write_data = 8'h00;
            s_write      = 1'b0;
         end
      endcase
   end

   assign init_start = (state_q == c_st_init);
   assign ksa_start  = (state_q == c_st_ksa);
   assign dec_start  = (state_q == c_st_dec);
   assign sub_reset  = (state_q == c_st_reset_subs);
   assign key_found  = (state_q == c_st_found);
   assign key_fail   = (state_q == c_st_exhausted);
   assign busy       = (state_q != c_st_idle) && (state_q != c_st_found) &&
                       (state_q != c_st_exhausted);
   assign key        = key_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_key_search_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_rc4_key_search_ctrl                                                    |
// | Scoreboard bench: behavioural init/KSA/decrypt models feed the sequencer. |
// | Honours RC4_EARLY_ABORT_EN for the expected sub_reset timing.             |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_rc4_key_search_ctrl;

   localparam int          MSG  = 4;
   localparam logic [23:0] KBEG = 24'h000000;
   localparam logic [23:0] KEND = 24'h000003;

   typedef struct packed {
      logic        found;
      logic        fail;
      logic [23:0] key;
   } res_t;

   logic        clk = 1'b0;
   logic        reset, start;
   logic        init_start, ksa_start, dec_start;
   logic        init_finish, ksa_finish, dec_finish;
   logic        sub_reset;
   logic [7:0]  init_s_address, ksa_s_address, dec_s_address;
   logic [7:0]  init_s_write_data, ksa_s_write_data, dec_s_write_data;
   logic        init_s_write, ksa_s_write, dec_s_write;
   logic [7:0]  s_address, s_write_data;
   logic        s_write;
   logic        dec_ram_write;
   logic [7:0]  dec_ram_write_data;
   logic [23:0] key;
   logic        key_found, key_fail, busy;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   int          scn    = 0;
   logic [15:0] wr_q[$];
   int          sr_q[$];
   res_t        res_q[$];
   logic [23:0] rst_q[$];

   rc4_key_search_ctrl #(
      .KEY_WIDTH(24), .KEY_START(KBEG), .KEY_END(KEND), .MSG_LEN(MSG)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .init_start(init_start), .ksa_start(ksa_start), .dec_start(dec_start),
      .init_finish(init_finish), .ksa_finish(ksa_finish), .dec_finish(dec_finish),
      .sub_reset(sub_reset),
      .init_s_address(init_s_address), .ksa_s_address(ksa_s_address),
      .dec_s_address(dec_s_address),
      .init_s_write_data(init_s_write_data), .ksa_s_write_data(ksa_s_write_data),
      .dec_s_write_data(dec_s_write_data),
      .init_s_write(init_s_write), .ksa_s_write(ksa_s_write), .dec_s_write(dec_s_write),
      .s_address(s_address), .s_write_data(s_write_data), .s_write(s_write),
      .dec_ram_write(dec_ram_write), .dec_ram_write_data(dec_ram_write_data),
      .key(key), .key_found(key_found), .key_fail(key_fail), .busy(busy)
   );

   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Hand-written plaintext per scenario/key/byte index.
   function automatic logic [7:0] pt_byte(int s, int k, int i);
      logic [7:0] b;
      b = 8'h61;
      case (s)
         0: begin
            if (k == 3) b = (i == 1) ? 8'h7A : (i == 2) ? 8'h20 : 8'h6D;
            else if (i == k) b = (k == 0) ? 8'h60 : (k == 1) ? 8'h7B : 8'h1F;
         end
         1: b = 8'h00;
         2: b = 8'h61;
         3: begin
            if (k == 3) b = (i == 0 || i == 3) ? 8'h20 : (i == 1) ? 8'h7A : 8'h61;
            else if (i == 3) b = (k == 0) ? 8'h60 : (k == 1) ? 8'h7B : 8'h1F;
         end
         4: b = (i == 1) ? 8'h20 : 8'h7A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic bit byte_bad(int s, int k, int i);
      case (s)
         0:       return (k < 3) && (i == k);
         1:       return 1'b1;
         3:       return (k < 3) && (i == 3);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int pt_len(int s);
      return (s == 2) ? 3 : MSG;
   endfunction

   function automatic bit key_good(int s, int k);
      return ((s == 0 || s == 3) && k == 3) || (s == 4 && k == 0);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Registered behavioural sub-blocks: react to what they saw last cycle.
   initial begin : sub_models
      int   ic, kc, dc, k;
      bit   ifin, kfin, dfin, sched, proceed;
      logic sr_s, is_s, ks_s, ds_s;
      logic [23:0] key_s;
      ic = 0; kc = 0; dc = 0; ifin = 0; kfin = 0; dfin = 0; sched = 0;
      init_finish = 0; ksa_finish = 0; dec_finish = 0;
      init_s_write = 0; init_s_address = 0; init_s_write_data = 0;
      ksa_s_write = 0; ksa_s_address = 0; ksa_s_write_data = 0;
      dec_s_write = 0; dec_s_address = 0; dec_s_write_data = 0;
      dec_ram_write = 0; dec_ram_write_data = 0;
      forever begin
         @(negedge clk);
         sr_s = sub_reset; is_s = init_start; ks_s = ksa_start; ds_s = dec_start; key_s = key;
         tick();
         init_s_write = 0; init_s_address = 0; init_s_write_data = 0;
         ksa_s_write = 0; ksa_s_address = 0; ksa_s_write_data = 0;
         dec_s_write = 0; dec_s_address = 0; dec_s_write_data = 0;
         dec_ram_write = 0; dec_ram_write_data = 0;
         k = int'(key_s);
         proceed = !key_good(scn, k) && (key_s != KEND);
         if (sr_s) begin
            ic = 0; kc = 0; dc = 0; ifin = 0; kfin = 0; dfin = 0; sched = 0;
         end else begin
            if (is_s && !ifin) begin
               if (ic == 4) ifin = 1;
               else begin
                  init_s_write = 1; init_s_address = 8'(ic); init_s_write_data = 8'hC0 + 8'(ic);
                  wr_q.push_back({init_s_address, init_s_write_data});
                  ic++;
               end
            end
            if (ks_s && !kfin) begin
               // A stale init requester keeps writing; it must not reach S.
               init_s_write = 1; init_s_address = 8'hAA; init_s_write_data = 8'hEE;
               if (kc == 4) kfin = 1;
               else begin
                  ksa_s_address = 8'h10 + 8'(kc); ksa_s_write_data = key_s[7:0] ^ 8'(kc);
                  if (kc != 1) begin
                     ksa_s_write = 1;
                     wr_q.push_back({ksa_s_address, ksa_s_write_data});
                  end
                  kc++;
               end
            end
            if (ds_s && !dfin) begin
               if (dc == 0) begin
                  dec_s_write = 1; dec_s_address = 8'h40; dec_s_write_data = key_s[7:0];
                  wr_q.push_back({dec_s_address, dec_s_write_data});
               end else begin
                  dec_ram_write = 1; dec_ram_write_data = pt_byte(scn, k, dc - 1);
`ifdef RC4_EARLY_ABORT_EN
                  if (!sched && byte_bad(scn, k, dc - 1)) begin
                     sched = 1;
                     if (proceed) sr_q.push_back(cyc + 2);
                  end
`endif
                  if (dc == pt_len(scn)) begin
                     dfin = 1;
                     if (!sched) begin
                        sched = 1;
                        if (proceed) sr_q.push_back(cyc + 2);
                     end
                  end
               end
               dc++;
            end
         end
         init_finish = ifin; ksa_finish = kfin; dec_finish = dfin;
      end
   end

   initial begin : mon_swrite
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (s_write === 1'b1) begin
            if (wr_q.size() == 0) check("s_write_unexpected", {16'h0, s_address, s_write_data}, 32'h0);
            else begin
               e = wr_q.pop_front();
               check("s_port_write", {16'h0, s_address, s_write_data}, {16'h0, e});
            end
         end
      end
   end

   initial begin : mon_subreset
      forever begin
         @(negedge clk);
         if (sub_reset === 1'b1) begin
            if (sr_q.size() == 0) check("sub_reset_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            else check("sub_reset_cycle", 32'(cyc), 32'(sr_q.pop_front()));
         end
      end
   end

   initial begin : mon_result
      logic done, done_prev;
      res_t e;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         done = key_found | key_fail;
         if (done && !done_prev) begin
            if (res_q.size() == 0) check("result_unexpected", {30'h0, key_found, key_fail}, 32'h0);
            else begin
               e = res_q.pop_front();
               check("res_key_found", 32'(key_found), 32'(e.found));
               check("res_key_fail", 32'(key_fail), 32'(e.fail));
               check("res_key", 32'(key), 32'(e.key));
               check("res_busy", 32'(busy), 32'h0);
            end
         end
         done_prev = done;
      end
   end

   initial begin : mon_reset
      logic rst_prev;
      logic [23:0] ek;
      rst_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_prev && !reset && rst_q.size() != 0) begin
            ek = rst_q.pop_front();
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_dec_start", 32'(dec_start), 32'h0);
            check("rst_key", 32'(key), 32'(ek));
            check("rst_s_write", 32'(s_write), 32'h0);
            check("rst_s_addr_data", {16'h0, s_address, s_write_data}, 32'h0);
            check("rst_flags", {26'h0, init_start, ksa_start, sub_reset, key_found, key_fail, busy}, 32'h0);
         end
         rst_prev = reset;
      end
   end

   task automatic wait_done(string name);
      bit seen;
      seen = 0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(negedge clk);
         if (key_found || key_fail) seen = 1;
      end
      if (!seen) check({name, "_timeout"}, 32'h0, 32'h1);
      tick();
      tick();
   endtask

   task automatic run_search(int s, bit ef, logic [23:0] ek, string name);
      res_t r;
      scn = s;
      r.found = ef; r.fail = !ef; r.key = ek;
      res_q.push_back(r);
      tick();
      start = 1'b1;
      sr_q.push_back(cyc + 1);
      tick();
      start = 1'b0;
      wait_done(name);
   endtask

   initial begin : stim
      bit hit;
      reset = 1'b1;
      start = 1'b0;
      rst_q.push_back(KBEG);
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();

      run_search(0, 1'b1, 24'h000003, "find_key3");
      run_search(1, 1'b0, 24'h000003, "exhaust_zero");
      run_search(2, 1'b0, 24'h000003, "exhaust_short");
      run_search(3, 1'b1, 24'h000003, "last_byte_bad");
      run_search(4, 1'b1, 24'h000000, "first_key");

      // Reset while decrypting key 2 of an all-bad search.
      scn = 1;
      tick();
      start = 1'b1;
      sr_q.push_back(cyc + 1);
      tick();
      start = 1'b0;
      hit = 0;
      for (int n = 0; n < 3000 && !hit; n++) begin
         @(negedge clk);
         if (dec_start && key == 24'h000002) hit = 1;
      end
      if (!hit) check("reset_test_reach_dec", 32'h0, 32'h1);
      tick();
      reset = 1'b1;
      rst_q.push_back(KBEG);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      wr_q.delete();
      sr_q.delete();

      run_search(4, 1'b1, 24'h000000, "after_reset");

      repeat (3) tick();
      check("pending_writes", 32'(wr_q.size()), 32'h0);
      check("pending_sub_resets", 32'(sr_q.size()), 32'h0);
      check("pending_results", 32'(res_q.size()), 32'h0);
      check("pending_resets", 32'(rst_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
